shift_register_ctrl: RTL and testbench
======================================

// Module: shift_register_ctrl
// PURPOSE
//  Sequencer for a WIDTH-deep clock-enabled serial shift register (e.g. SRL chain).
//  - Accepts parallel words on a valid/ready handshake.
//  - Serialises each word into the chain by driving its clock enable and serial input.
//  - Captures the word that shifts out of the chain, returning it on a parallel port.
//  - Sits between a host/config engine and one shift-register datapath instance.
// PARAMETERS
//  WIDTH      32  chain depth and word width in bits; legal range 2..64
//  MSB_FIRST  1   1: load_data[WIDTH-1] is shifted in first; 0: load_data[0] is shifted in first
// PORTS
//  clk_in         in   1      rising-edge clock, shared with the controlled chain
//  rst_n_in       in   1      reset, asynchronous and active-low
//  load_valid     in   1      host has a word on load_data
//  load_ready     out  1      controller can accept a word (IDLE only)
//  load_data      in   WIDTH  word to shift into the chain
//  hold_in        in   1      pause shifting while high
//  sr_clk_en      out  1      drives clk_en of the chain
//  sr_serial_in   out  1      drives serial_in of the chain
//  sr_serial_out  in   1      serial_out of the chain (its registered MSB)
//  busy           out  1      high in SHIFT and DONE
//  cap_valid      out  1      one-cycle pulse: word transfer complete
//  cap_data       out  WIDTH  previous chain contents, same bit order as load_data
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, shift/capture buffers=0.
//   Outputs at reset: load_ready=1, sr_clk_en=0, sr_serial_in=0, busy=0, cap_valid=0, cap_data=0.
//   Chain contents are not reset; the first cap_data after reset is whatever the chain held.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE -> SHIFT on load_valid&&load_ready. On that edge:
//    - latch load_data into tx buffer, bit-reversed when MSB_FIRST=0
//    - clear counter
//   SHIFT: stays for exactly WIDTH enabled cycles.
//    - sr_clk_en = !hold_in (combinational)
//    - sr_serial_in = tx buffer MSB
//    - On each enabled edge:
//      - tx <= tx<<1
//      - cap_shift <= {cap_shift[WIDTH-2:0], sr_serial_out}
//      - counter++
//    - hold_in=1: no shift, no capture sample, counter frozen, sr_serial_in stable.
//   SHIFT -> DONE on the enabled edge where counter==WIDTH-1.
//   DONE (1 cycle): sr_clk_en=0, cap_valid=1, load_ready=0, busy=1; -> IDLE unconditionally.
//    - cap_data loads on SHIFT->DONE (bit-reversed when MSB_FIRST=0); held until the next DONE.
//  Latency, no hold: accept at edge t -> enabled edges t+1..t+WIDTH -> cap_valid high in cycle after t+WIDTH.
//   Each hold cycle adds one cycle.
//  Throughput: one word per WIDTH+2 cycles; no back-to-back accept from DONE.
//  Boundaries:
//   - load_valid while busy: ignored; host must hold it (load_ready=0).
//   - hold_in in IDLE or DONE: no effect.
//   - hold_in high on the final enabled shift: DONE is delayed until that shift occurs.
//   - Reset mid-SHIFT: immediate abort to reset values; no cap_valid; chain left partially shifted.
//   - Counter width: $clog2(WIDTH)+1; no wrap possible.
//  sr_clk_en and sr_serial_in are glitch-free decodes of registered state and hold_in only.
// CONFIGURATION
//  SRL_CTRL_CAPTURE_EN
//   Defined: capture buffer and cap_data active as above.
//   Undefined:
//    - capture buffer not built; cap_data tied to 0
//    - sr_serial_out unused
//    - cap_valid still pulses in DONE as a completion strobe
//    - all other timing identical
// TESTING
//  Chain model: behavioural WIDTH-bit shift register driven by sr_clk_en/sr_serial_in.
//  T1 After reset, load 0xDEADBEEF then 0x12345678 (WIDTH=32, MSB_FIRST=1):
//     - first cap_data = chain power-on value
//     - second cap_data = 0xDEADBEEF
//     - model holds 0x12345678
//  T2 Latency: accept at cycle 10, hold_in=0 -> sr_clk_en high cycles 11..42;
//     cap_valid high only in cycle 43; load_ready high again in cycle 44.
//  T3 hold_in high for 5 cycles mid-SHIFT -> cap_valid delayed exactly 5 cycles;
//     model contents and cap_data identical to the unheld run.
//  T4 rst_n_in low at shift 17 of 32:
//     - outputs return to reset values asynchronously; no cap_valid
//     - next load 0xA5A5A5A5 completes normally
//  T5 MSB_FIRST=0, load 0x00000001 twice:
//     - model holds 0x80000000 after each load
//     - second cap_data = 0x00000001
//  T6 SRL_CTRL_CAPTURE_EN undefined, load 0xFFFFFFFF -> cap_valid pulses, cap_data=0;
//     load_valid held during busy -> exactly one accept per word.

Source files
------------

// File: rtl/shift_register_ctrl_if.sv
// Host and chain signals of the shift-register sequencer.
// The controller uses the slave modport; the host/chain side uses master.
interface shift_register_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             hold_in;
    logic             sr_clk_en;
    logic             sr_serial_in;
    logic             sr_serial_out;
    logic             busy;
    logic             cap_valid;
    logic [WIDTH-1:0] cap_data;

    modport slave (
        input  load_valid, load_data, hold_in, sr_serial_out,
        output load_ready, sr_clk_en, sr_serial_in, busy, cap_valid, cap_data
    );

    modport master (
        output load_valid, load_data, hold_in, sr_serial_out,
        input  load_ready, sr_clk_en, sr_serial_in, busy, cap_valid, cap_data
    );
endinterface

// File: rtl/shift_register_ctrl.sv
// Serialises parallel words into a clock-enabled shift chain and captures the word shifted out.
// Define SRL_CTRL_CAPTURE_EN to build the capture path; otherwise cap_data is 0 and cap_valid is a completion strobe.
module shift_register_ctrl #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    shift_register_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] tx;
    logic             accept;
    logic             shift_en;
    logic             last;

    // The chain always shifts MSB-first, so LSB-first words are reversed on entry and exit.
    function automatic logic [WIDTH-1:0] order(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v;
        if (!MSB_FIRST)
            for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    assign accept   = (state == IDLE) && bus.load_valid;
    assign shift_en = (state == SHIFT) && !bus.hold_in;
    assign last     = shift_en && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        bus.load_ready   = 1'b0;
        bus.busy         = 1'b0;
        bus.sr_clk_en    = 1'b0;
        bus.sr_serial_in = 1'b0;
        bus.cap_valid    = 1'b0;
        case (state)
            IDLE: begin
                bus.load_ready = 1'b1;
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                bus.busy         = 1'b1;
                bus.sr_clk_en    = shift_en;
                bus.sr_serial_in = tx[WIDTH-1];
                if (last) state_nxt = DONE;
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.cap_valid = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt <= '0;
            tx  <= '0;
        end else if (accept) begin
            cnt <= '0;
            tx  <= order(bus.load_data);
        end else if (shift_en) begin
            cnt <= cnt + 1'b1;
            tx  <= tx << 1;
        end
    end

`ifdef SRL_CTRL_CAPTURE_EN
    logic [WIDTH-1:0] cap_shift;
    logic [WIDTH-1:0] cap_data;

    // The final sample is folded straight into cap_data so it is valid in DONE.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cap_shift <= '0;
            cap_data  <= '0;
        end else if (shift_en) begin
            cap_shift <= {cap_shift[WIDTH-2:0], bus.sr_serial_out};
            if (last) cap_data <= order({cap_shift[WIDTH-2:0], bus.sr_serial_out});
        end
    end

    assign bus.cap_data = cap_data;
`else
    logic unused_serial_out;
    assign unused_serial_out = bus.sr_serial_out;
    assign bus.cap_data      = '0;
`endif
endmodule

// File: tb/tb_shift_register_ctrl.sv
// Randomised bench: an MSB-first and an LSB-first controller share stimulus, each driving its own chain model.
module tb_shift_register_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_valid;
    logic         hold;
    logic [W-1:0] load_data;
    logic [W-1:0] chain_m, chain_l;
    logic [W-1:0] exp_cap_m, exp_cap_l;
    int           errs = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    shift_register_ctrl_if #(.WIDTH(W)) bus_m ();
    shift_register_ctrl_if #(.WIDTH(W)) bus_l ();

    assign bus_m.load_valid    = load_valid;
    assign bus_m.load_data     = load_data;
    assign bus_m.hold_in       = hold;
    assign bus_m.sr_serial_out = chain_m[W-1];
    assign bus_l.load_valid    = load_valid;
    assign bus_l.load_data     = load_data;
    assign bus_l.hold_in       = hold;
    assign bus_l.sr_serial_out = chain_l[W-1];

    shift_register_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk_in(clk), .rst_n_in(rst_n), .bus(bus_m));
    shift_register_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk_in(clk), .rst_n_in(rst_n), .bus(bus_l));

    // Behavioural chains; never reset.
    always @(posedge clk) begin
        if (bus_m.sr_clk_en) chain_m <= {chain_m[W-2:0], bus_m.sr_serial_in};
        if (bus_l.sr_clk_en) chain_l <= {chain_l[W-2:0], bus_l.sr_serial_in};
    end

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {load_ready, busy, sr_clk_en, sr_serial_in, cap_valid}
    task automatic chk_flags(input string tag, input logic [4:0] em, input logic [4:0] el);
        chk({tag, "_m"}, {bus_m.load_ready, bus_m.busy, bus_m.sr_clk_en, bus_m.sr_serial_in, bus_m.cap_valid}, em);
        chk({tag, "_l"}, {bus_l.load_ready, bus_l.busy, bus_l.sr_clk_en, bus_l.sr_serial_in, bus_l.cap_valid}, el);
    endtask

    task automatic chk_cap(input string tag);
        chk({tag, "_cap_m"}, bus_m.cap_data, exp_cap_m);
        chk({tag, "_cap_l"}, bus_l.cap_data, exp_cap_l);
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // One word transfer, optionally with a hold burst and/or a reset after rst_at shifts.
    task automatic run_word(input logic [W-1:0] d, input int hold_at, input int hold_len,
                            input bit keep_valid, input int rst_at);
        logic [W-1:0] pre_m, pre_l;
        int k, hl;
        pre_m = chain_m;
        pre_l = chain_l;
        load_data  = d;
        load_valid = 1'b1;
        hold       = 1'($urandom_range(0, 1));
        #1;
        chk_flags("idle", 5'b10000, 5'b10000);
        chk_cap("idle");
        cyc();
        if (!keep_valid) begin
            load_valid = 1'b0;
            load_data  = W'($urandom);
        end
        k  = 0;
        hl = hold_len;
        while (k < W) begin
            hold = (k == hold_at) && (hl > 0);
            #1;
            chk_flags("shift", {2'b01, !hold, d[W-1-k], 1'b0}, {2'b01, !hold, d[k], 1'b0});
            if (k == 0 || hold) chk_cap("held");
            if (k == rst_at && !hold) begin
                rst_n = 1'b0;
                #1;
                exp_cap_m = '0;
                exp_cap_l = '0;
                chk_flags("rst", 5'b10000, 5'b10000);
                chk_cap("rst");
                cyc();
                load_valid = 1'b0;
                hold       = 1'b0;
                rst_n      = 1'b1;
                cyc();
                chk_flags("post_rst", 5'b10000, 5'b10000);
                chk_cap("post_rst");
                return;
            end
            if (hold) hl--;
            else      k++;
            cyc();
        end
        hold = 1'($urandom_range(0, 1));
        #1;
`ifdef SRL_CTRL_CAPTURE_EN
        exp_cap_m = pre_m;
        exp_cap_l = rev(pre_l);
`else
        exp_cap_m = '0;
        exp_cap_l = '0;
`endif
        chk_flags("done", 5'b01001, 5'b01001);
        chk_cap("done");
        cyc();
        load_valid = 1'b0;
        hold       = 1'b0;
        #1;
        chk_flags("after", 5'b10000, 5'b10000);
        chk_cap("after");
        chk("chain_m", chain_m, d);
        chk("chain_l", chain_l, rev(d));
        cyc();
        chk_flags("one_accept", 5'b10000, 5'b10000);
    endtask

    initial begin
        chain_m    = W'($urandom);
        chain_l    = W'($urandom);
        exp_cap_m  = '0;
        exp_cap_l  = '0;
        load_valid = 1'b0;
        hold       = 1'b0;
        load_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_flags("reset", 5'b10000, 5'b10000);
        chk_cap("reset");
        rst_n = 1'b1;
        cyc();

        run_word(32'hDEADBEEF, W, 0, 1'b0, W);
        run_word(32'h12345678, W, 0, 1'b1, W);
        run_word(32'hCAFEF00D, 10, 5, 1'b0, W);
        run_word(32'h0F0F1234, W - 1, 3, 1'b1, W);
        run_word(32'h0BADC0DE, 0, 2, 1'b0, W);
        run_word(32'h55AA55AA, W, 0, 1'b1, 17);
        run_word(32'hA5A5A5A5, W, 0, 1'b0, W);
        run_word(32'h00000001, W, 0, 1'b0, W);
        run_word(32'h00000001, W, 0, 1'b0, W);
        run_word(32'hFFFFFFFF, W, 0, 1'b1, W);
        for (int n = 0; n < 24; n++)
            run_word(W'($urandom), int'($urandom_range(0, W)), int'($urandom_range(0, 4)),
                     1'($urandom_range(0, 1)), W);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
